// File: rtl/mult_seq.sv
// mult_seq: iterative 32x32 shift-add multiplier with start/done handshake.
// Signed operation multiplies magnitudes and negates the 64-bit result at the end.
module mult_seq (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mult_begin,
  input  logic        mult_signed,
  input  logic [31:0] mult_op1,
  input  logic [31:0] mult_op2,
  output logic        busy,
  output logic        mult_end,
  output logic [63:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [63:0] mcand_q;
  logic [31:0] mplier_q;
  logic [63:0] acc_q;
  logic [4:0]  cnt_q;
  logic        neg_q;
  logic [63:0] product_q;
  logic        mult_end_q;

  logic [31:0] op1_sel_d;
  logic [31:0] op2_sel_d;
  logic [63:0] acc_d;

  // Operand magnitudes at accept (|-2^31| is 32'h8000_0000 as unsigned) and the next accumulator value.
  always_comb begin
    op1_sel_d = mult_op1;
    op2_sel_d = mult_op2;
    if (mult_signed) begin
      if (mult_op1[31]) op1_sel_d = ~mult_op1 + 32'd1;
      if (mult_op2[31]) op2_sel_d = ~mult_op2 + 32'd1;
    end
    acc_d = acc_q;
    if (mplier_q[0]) acc_d = acc_q + mcand_q;
  end

  // Control FSM and datapath: accept in IDLE, 32 shift-add steps in RUN, sign fix-up and pulse in DONE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      mcand_q    <= 64'd0;
      mplier_q   <= 32'd0;
      acc_q      <= 64'd0;
      cnt_q      <= 5'd0;
      neg_q      <= 1'b0;
      product_q  <= 64'd0;
      mult_end_q <= 1'b0;
    end else begin
      mult_end_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mult_begin) begin
            state_q  <= RUN;
            mcand_q  <= {32'd0, op1_sel_d};
            mplier_q <= op2_sel_d;
            neg_q    <= mult_signed & (mult_op1[31] ^ mult_op2[31]);
            acc_q    <= 64'd0;
            cnt_q    <= 5'd0;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= {mcand_q[62:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[31:1]};
          cnt_q    <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= DONE;
        end
        DONE: begin
          product_q  <= neg_q ? (~acc_q + 64'd1) : acc_q;
          mult_end_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = (state_q != IDLE);
  assign mult_end = mult_end_q;
  assign product  = product_q;

endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: directed scoreboard bench for the sequential multiplier.
module tb_mult_seq;

  logic        clk;
  logic        resetn;
  logic        mult_begin;
  logic        mult_signed;
  logic [31:0] mult_op1;
  logic [31:0] mult_op2;
  logic        busy;
  logic        mult_end;
  logic [63:0] product;

  int checks = 0;
  int errors = 0;
  logic [63:0] sbQ[$];

  mult_seq dut (
    .clk        (clk),
    .resetn     (resetn),
    .mult_begin (mult_begin),
    .mult_signed(mult_signed),
    .mult_op1   (mult_op1),
    .mult_op2   (mult_op2),
    .busy       (busy),
    .mult_end   (mult_end),
    .product    (product)
  );

  // 10 MHz board clock.
  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Called at a negedge; drives the request, records the expectation, and returns 1ns after the accept edge.
  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] exp, input bit expectEnd);
    mult_signed = sgn;
    mult_op1    = a;
    mult_op2    = b;
    mult_begin  = 1'b1;
    if (expectEnd) sbQ.push_back(exp);
    @(posedge clk);
    #1;
    mult_begin  = 1'b0;
    mult_signed = $urandom_range(0, 1);
    mult_op1    = $urandom;
    mult_op2    = $urandom;
  endtask

  // Waits (bounded) for mult_end, then checks latency, busy and the popped product; returns at that negedge.
  task automatic checkOutput(input string tag);
    int cycles = 0;
    bit seen = 0;
    logic [63:0] exp;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      cycles++;
      if (mult_end) begin
        seen = 1;
        break;
      end
    end
    chk({tag, "_seen"}, 64'(seen), 64'd1);
    chk({tag, "_latency"}, 64'(cycles), 64'd34);
    chk({tag, "_busy_low"}, 64'(busy), 64'd0);
    exp = (sbQ.size() > 0) ? sbQ.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    chk({tag, "_product"}, product, exp);
  endtask

  initial begin
    int endCount;
    logic [63:0] held;
    logic [31:0] ra, rb;
    logic rs;

    resetn      = 1'b0;
    mult_begin  = 1'b0;
    mult_signed = 1'b0;
    mult_op1    = 32'd0;
    mult_op2    = 32'd0;
    #10;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_end", 64'(mult_end), 64'd0);
    chk("reset_product", product, 64'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    $display("[TB] unsigned max operands");
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1);
    chk("busy_after_accept", 64'(busy), 64'd1);
    checkOutput("umax");

    $display("[TB] signed and unsigned -7 x 6");
    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, 1);
    checkOutput("s_m7x6");
    applyStimulus(1'b0, 32'hFFFF_FFF9, 32'd6, 64'h0000_0005_FFFF_FFD6, 1);
    checkOutput("u_m7x6");

    $display("[TB] signed boundary");
    applyStimulus(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1);
    checkOutput("s_min_sq");
    applyStimulus(1'b1, 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000, 1);
    checkOutput("s_min_x1");

    $display("[TB] begin held while busy, then back-to-back");
    applyStimulus(1'b0, 32'd3, 32'd5, 64'd15, 1);
    mult_signed = 1'b0;
    mult_op1    = 32'd9;
    mult_op2    = 32'd9;
    mult_begin  = 1'b1;
    checkOutput("ignore_3x5");
    applyStimulus(1'b0, 32'd9, 32'd9, 64'd81, 1);
    checkOutput("b2b_9x9");

    $display("[TB] reset mid-operation");
    applyStimulus(1'b0, 32'd100, 32'd100, 64'd0, 0);
    repeat (10) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_product", product, 64'd0);
    chk("midrst_end", 64'(mult_end), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    endCount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mult_end) endCount++;
    end
    chk("midrst_no_end", 64'(endCount), 64'd0);
    applyStimulus(1'b0, 32'd2, 32'd3, 64'd6, 1);
    checkOutput("after_rst_2x3");

    $display("[TB] random operands");
    for (int i = 0; i < 4; i++) begin
      rs = i[0];
      ra = $urandom;
      rb = $urandom;
      applyStimulus(rs, ra, rb, model(rs, ra, rb), 1);
      checkOutput("random");
    end

    $display("[TB] zero operand and hold");
    applyStimulus(1'b1, 32'd0, 32'h1234_5678, 64'd0, 1);
    checkOutput("zero");
    applyStimulus(1'b1, 32'hFFFF_FF00, 32'h0000_1234, model(1'b1, 32'hFFFF_FF00, 32'h0000_1234), 1);
    checkOutput("pre_hold");
    held = model(1'b1, 32'hFFFF_FF00, 32'h0000_1234);
    for (int i = 0; i < 100; i++) begin
      mult_signed = $urandom_range(0, 1);
      mult_op1    = $urandom;
      mult_op2    = $urandom;
      @(negedge clk);
      chk("hold_product", product, held);
    end
    chk("hold_end_low", 64'(mult_end), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_seq.md
# mult_seq

Iterative 32x32 shift-add multiplier that sits beside the ALU in the operand/result datapath of the lab display top. It takes the two 32-bit source operands held by the touchscreen input logic and produces a 64-bit product over 34 cycles, using a start/done handshake. The display logic shows the product as two 32-bit display values. Both signed (two's-complement) and unsigned operation are supported.

## Interface
- No parameters; operand width is fixed at 32 bits and product width at 64 bits.
- clk  input  1  system clock (10 MHz on board)
- resetn  input  1  asynchronous active-low reset
- mult_begin  input  1  start request; accepted only while busy=0
- mult_signed  input  1  1: treat operands as two's-complement; 0: unsigned; sampled at accept
- mult_op1  input  32  multiplicand; sampled at accept
- mult_op2  input  32  multiplier; sampled at accept
- busy  output  1  high while an operation is in progress (state != IDLE)
- mult_end  output  1  one-cycle pulse: product valid and updated
- product  output  64  registered result; holds its value until the next completion

## Operation
- States: IDLE, RUN, DONE.
- IDLE: on a clk edge with mult_begin=1, the block accepts the operation and goes to RUN.
  - If mult_signed=1, it latches |op1| zero-extended to 64 bits into the multiplicand register and |op2| into the 32-bit multiplier register. It sets neg = op1[31] ^ op2[31].
  - If mult_signed=0, it latches the raw operands and sets neg = 0.
  - It clears the 64-bit accumulator and the 5-bit iteration counter.
- Absolute value of -2^31 is 2^31, which must be held correctly as unsigned 32 bits. No special case is allowed.
- RUN, once per cycle:
  - If multiplier[0]=1, the accumulator adds the multiplicand. The add is 64-bit and cannot overflow.
  - The multiplicand shifts left 1, the multiplier shifts right 1, and the counter increments.
  - After the 32nd iteration (counter wraps 31 -> 0), go to DONE.
- DONE: product <= neg ? (~acc + 1) : acc, mult_end <= 1, then go to IDLE.
- mult_begin while busy=1 is ignored. It is neither queued nor allowed to disturb the operation in flight.
- Operand inputs may change freely after the accept edge.
- Reset asserted at any time: state goes to IDLE and all outputs return to their reset values. Any in-flight operation is discarded and produces no mult_end.

## Timing
- Reset values: busy=0, mult_end=0, product=64'd0. All internal registers are 0 and state=IDLE.
- Let E0 be the accept edge.
  - RUN iterations occur on E1..E32.
  - DONE executes on E33.
  - product is updated and mult_end=1 for exactly the cycle following E33.
- Latency from accept edge to mult_end is 34 cycles.
- busy goes high after E0 and low after E33, so busy=0 in the same cycle that mult_end=1.
- A new mult_begin in the mult_end cycle is accepted on the next edge, giving back-to-back throughput of one operation per 34 cycles.
- mult_end is never high for two consecutive cycles.
- Async reset takes effect immediately on resetn falling, not at the next clock edge. Release is synchronous to the operation: the first accept is possible on the first edge with resetn=1.

## Test plan
- Unsigned: op1=32'hFFFF_FFFF, op2=32'hFFFF_FFFF, signed=0 -> product=64'hFFFF_FFFE_0000_0001, mult_end exactly 34 cycles after accept.
- Signed mixed signs: op1=-7 (32'hFFFF_FFF9), op2=6, signed=1 -> product=64'hFFFF_FFFF_FFFF_FFD6 (-42). Same operands with signed=0 -> 64'h0000_0005_FFFF_FFD6.
- Signed boundary: op1=op2=32'h8000_0000, signed=1 -> product=64'h4000_0000_0000_0000. op1=32'h8000_0000, op2=1 -> 64'hFFFF_FFFF_8000_0000.
- Busy and ignore:
  - Start 3x5, then assert mult_begin with 9x9 on cycles 1..33 while busy=1 -> single mult_end with product=15.
  - A following start of 9x9 issued in the mult_end cycle -> product=81 exactly 34 cycles later.
- Reset mid-operation: start 100x100, pulse resetn low at iteration 10 -> busy=0 and product=0 immediately, no mult_end. A subsequent 2x3 yields product=6.
- Zero and hold: op1=0, op2=32'h1234_5678 -> product=0 with mult_end. product then holds its value, unchanged, for 100 idle cycles while the operand inputs toggle.
